// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code set 2 byte constants, decoder states and event layout
package ps2_pkg;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;
  localparam int EV_W = 10;
  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_REL, ST_EXT_REL, ST_PAUSE} state_t;
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_ev_t;
endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: receiver byte strobe in, decoded key events out
interface ps2_key_decoder_if;
  logic [7:0] rx_data;
  logic       rx_complete;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_extended;
  logic       ev_release;
  logic       overflow;
  logic       error;
  modport master (output rx_data, rx_complete, ev_ready,
                  input  ev_valid, ev_code, ev_extended, ev_release, overflow, error);
  modport slave  (input  rx_data, rx_complete, ev_ready,
                  output ev_valid, ev_code, ev_extended, ev_release, overflow, error);
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word-fall-through event buffer, head reads 0 when empty
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = EV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  // pointers and occupancy; a push while full is accepted only alongside a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: folds set-2 prefix sequences into buffered key events
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic clk100,
  input logic rst,
  ps2_key_decoder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t        st_q, st_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d, ovf_q;
  logic          emit, pop, full, empty;
  ps2_ev_t       ev, head;
  assign pop             = bus.ev_ready && !empty;
  assign bus.ev_valid    = !empty;
  assign bus.ev_code     = head.code;
  assign bus.ev_extended = head.ext;
  assign bus.ev_release  = head.rel;
  assign bus.overflow    = ovf_q;
  assign bus.error       = err_q;
  // decode one byte per strobe; otherwise run the partial-sequence timeout
  always_comb begin
    st_d   = st_q;
    skip_d = skip_q;
    emit   = 1'b0;
    err_d  = 1'b0;
    ev     = '0;
    tmo_d  = st_q == ST_IDLE ? '0 : tmo_q + TW'(1);
    if (bus.rx_complete) begin
      tmo_d   = '0;
      ev.code = bus.rx_data;
      case (st_q)
        ST_IDLE: begin
          st_d   = bus.rx_data == PS2_EXT ? ST_EXT :
                   bus.rx_data == PS2_BREAK ? ST_REL :
                   bus.rx_data == PS2_PAUSE ? ST_PAUSE : ST_IDLE;
          skip_d = 3'd7;
          err_d  = bus.rx_data inside {PS2_ERR0, PS2_ERR1};
          emit   = !(bus.rx_data inside {PS2_EXT, PS2_BREAK, PS2_PAUSE, PS2_BAT_OK,
                                         PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_ERR0, PS2_ERR1});
        end
        ST_EXT: begin
          st_d   = bus.rx_data == PS2_BREAK ? ST_EXT_REL :
                   bus.rx_data == PS2_EXT ? ST_EXT : ST_IDLE;
          emit   = st_d == ST_IDLE;
          ev.ext = 1'b1;
        end
        ST_REL: begin
          st_d   = ST_IDLE;
          emit   = 1'b1;
          ev.rel = 1'b1;
        end
        ST_EXT_REL: begin
          st_d   = ST_IDLE;
          emit   = 1'b1;
          ev.ext = 1'b1;
          ev.rel = 1'b1;
        end
        ST_PAUSE: begin
          skip_d = skip_q - 3'd1;
          emit   = skip_q == 3'd1;
          st_d   = emit ? ST_IDLE : ST_PAUSE;
          ev     = {1'b1, 1'b0, PS2_PAUSE};
        end
        default: st_d = ST_IDLE;
      endcase
    end else if (st_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      st_d  = ST_IDLE;
      tmo_d = '0;
      err_d = 1'b1;
    end
  end
  // decoder state, timeout counter and registered pulses
  always_ff @(posedge clk100) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      skip_q <= '0;
      tmo_q  <= '0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      skip_q <= skip_d;
      tmo_q  <= tmo_d;
      err_q  <= err_d;
      ovf_q  <= emit && full && !pop;
    end
  end
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EV_W)) u_fifo (
    .clk    (clk100),
    .rst    (rst),
    .push_i (emit),
    .pop_i  (pop),
    .din_i  (ev),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench with a prefix-queue reference model
module tb_ps2_key_decoder;
  localparam int T = 40;
  localparam int D = 4;
  logic clk100 = 1'b0;
  logic rst = 1'b1;
  ps2_key_decoder_if bus ();
  ps2_key_decoder #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
    .clk100(clk100),
    .rst   (rst),
    .bus   (bus)
  );
  always #5 clk100 = ~clk100;
  logic [9:0] exp_q[$];
  logic [7:0] pend[$];
  int tests = 0, fails = 0;
  int exp_err = 0, exp_ovf = 0, got_err = 0, got_ovf = 0;
  int cyc = 0, last_stb = 0;
  task automatic chk(input string n, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  task automatic push_ev(input logic e, input logic r, input logic [7:0] c);
    if (exp_q.size() >= D && !bus.ev_ready) exp_ovf++;
    else exp_q.push_back({e, r, c});
  endtask
  task automatic model(input logic [7:0] b);
    logic ext, rel;
    if (pend.size() != 0 && cyc - last_stb > T) begin
      exp_err++;
      pend.delete();
    end
    last_stb = cyc;
    if (pend.size() == 0) begin
      if (b inside {8'hE0, 8'hF0, 8'hE1}) pend.push_back(b);
      else if (b == 8'h00 || b == 8'hFF) exp_err++;
      else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE})) push_ev(1'b0, 1'b0, b);
    end else if (pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin
        push_ev(1'b1, 1'b0, 8'hE1);
        pend.delete();
      end
    end else begin
      ext = pend[0] == 8'hE0;
      rel = pend[pend.size()-1] == 8'hF0;
      if (rel) begin
        push_ev(ext, 1'b1, b);
        pend.delete();
      end else if (b == 8'hF0) pend.push_back(b);
      else if (b != 8'hE0) begin
        push_ev(1'b1, 1'b0, b);
        pend.delete();
      end
    end
  endtask
  task automatic step(input logic stb, input logic [7:0] b, input logic rdy);
    bus.ev_ready    = rdy;
    bus.rx_complete = stb;
    bus.rx_data     = stb ? b : 8'h00;
    if (stb) model(b);
    @(posedge clk100);
    #1;
    cyc++;
    bus.rx_complete = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic rdy);
    step(1'b1, b, rdy);
  endtask
  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, 8'h00, rdy);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.ev_ready = 1'b0;
    bus.rx_complete = 1'b0;
    exp_q.delete();
    pend.delete();
    @(posedge clk100);
    #1;
    cyc++;
    rst = 1'b0;
  endtask
  task automatic checkpoint(input string n);
    if (pend.size() != 0 && cyc - last_stb > T) begin
      exp_err++;
      pend.delete();
    end
    chk({n, "_err"}, got_err, exp_err);
    chk({n, "_ovf"}, got_ovf, exp_ovf);
    chk({n, "_drain"}, exp_q.size(), 0);
  endtask
  // scoreboard monitor: pulses and accepted events, sampled mid-cycle
  always @(negedge clk100) begin
    if (!rst) begin
      if (bus.error) got_err++;
      if (bus.overflow) got_ovf++;
      if (bus.ev_valid && bus.ev_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL ev_unexpected got=%0h exp=none",
                   {bus.ev_extended, bus.ev_release, bus.ev_code});
        end else begin
          automatic logic [9:0] e = exp_q.pop_front();
          if ({bus.ev_extended, bus.ev_release, bus.ev_code} !== e) begin
            fails++;
            $display("FAIL ev_head got=%0h exp=%0h",
                     {bus.ev_extended, bus.ev_release, bus.ev_code}, e);
          end
        end
      end
    end
  end
  initial begin
    logic [7:0] b;
    logic [7:0] st_bytes [4] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE};
    bus.rx_data = 8'h00;
    bus.rx_complete = 1'b0;
    bus.ev_ready = 1'b0;
    do_reset();
    chk("rst_valid", bus.ev_valid, 0);
    chk("rst_code", bus.ev_code, 0);
    chk("rst_ext", bus.ev_extended, 0);
    chk("rst_rel", bus.ev_release, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_err", bus.error, 0);
    send(8'h1C, 1'b1);
    chk("lat_valid", bus.ev_valid, 1);
    chk("lat_code", bus.ev_code, 8'h1C);
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    chk("brk_valid", bus.ev_valid, 1);
    chk("brk_rel", bus.ev_release, 1);
    idle(3, 1'b1);
    checkpoint("basic");
    foreach (st_bytes[i]) send(st_bytes[i], 1'b1);
    idle(3, 1'b1);
    checkpoint("status");
    send(8'hFF, 1'b1);
    idle(3, 1'b1);
    checkpoint("err_ff");
    send(8'hE0, 1'b1); send(8'h75, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1);
    send(8'hE0, 1'b1); send(8'hE0, 1'b1); send(8'h6B, 1'b1);
    send(8'hE1, 1'b1); send(8'h14, 1'b1); send(8'h77, 1'b1); send(8'hE1, 1'b1);
    send(8'hF0, 1'b1); send(8'h14, 1'b1); send(8'hF0, 1'b1); send(8'h77, 1'b1);
    send(8'h1C, 1'b1);
    idle(3, 1'b1);
    checkpoint("prefix");
    send(8'hE0, 1'b1);
    idle(T + 2, 1'b1);
    send(8'h1C, 1'b1);
    idle(3, 1'b1);
    checkpoint("timeout");
    send(8'hE0, 1'b1);
    idle(T - 1, 1'b1);
    send(8'h75, 1'b1);
    idle(3, 1'b1);
    checkpoint("expiry_byte");
    send(8'h15, 1'b0); send(8'h1D, 1'b0); send(8'h24, 1'b0);
    send(8'h2D, 1'b0); send(8'h2C, 1'b0);
    idle(2, 1'b0);
    chk("full_ovf", got_ovf, exp_ovf);
    chk("full_head", bus.ev_code, 8'h15);
    send(8'h3C, 1'b1);
    idle(2, 1'b0);
    chk("pushpop_ovf", got_ovf, exp_ovf);
    idle(8, 1'b1);
    checkpoint("overflow");
    send(8'h16, 1'b0);
    send(8'hE0, 1'b0);
    do_reset();
    chk("midrst_valid", bus.ev_valid, 0);
    send(8'h1C, 1'b1);
    idle(3, 1'b1);
    checkpoint("after_rst");
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 15))
        0: b = 8'hE0;
        1, 2: b = 8'hF0;
        3: b = 8'hE1;
        4: b = st_bytes[$urandom_range(0, 3)];
        5: b = $urandom_range(0, 1) ? 8'hFF : 8'h00;
        default: b = 8'($urandom);
      endcase
      send(b, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) idle(T - 2 + $urandom_range(0, 2), $urandom_range(0, 3) != 0);
      else repeat ($urandom_range(0, 3)) step(1'b0, 8'h00, $urandom_range(0, 3) != 0);
    end
    idle(T + 5, 1'b1);
    checkpoint("random");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Sequencing controller that sits directly behind the PS/2 receiver on clk100. It consumes the receiver's byte strobes and decodes scan-code set 2 prefix sequences (E0, F0, E1 pause) into single key events. It drops keyboard status bytes and recovers from truncated sequences by timeout. Decoded events are buffered in a small FIFO with a valid/ready interface for the terminal input logic.

Parameters:
FIFO_DEPTH, 4, number of buffered events; power of two, minimum 2.
TIMEOUT_CYCLES, 200000, clk100 cycles without a byte before a partial sequence is abandoned (2 ms at 100 MHz).

Ports:
clk100  in  1  system clock; the only clock.
rst  in  1  reset; synchronous, active-high.
rx_data  in  8  byte from the PS/2 receiver; valid only when rx_complete=1.
rx_complete  in  1  one-cycle strobe, one per received byte.
ev_valid  out  1  FIFO non-empty; the head event is presented.
ev_ready  in  1  consumer accepts the head event when ev_valid and ev_ready are both 1.
ev_code  out  8  scan code of the head event.
ev_extended  out  1  head event was E0-prefixed, or is the pause key.
ev_release  out  1  head event is a break (F0-prefixed).
overflow  out  1  one-cycle pulse when a decoded event is dropped because the FIFO is full.
error  out  1  one-cycle pulse on a keyboard error byte (00/FF) or on a sequence timeout.

Behaviour:
- Reset (synchronous, rst=1 at a clk100 edge): state IDLE, FIFO empty, timeout counter 0, ev_valid/overflow/error=0. ev_code/ev_extended/ev_release read 0 while the FIFO is empty.
- A byte is processed only in cycles with rx_complete=1. All decode work finishes in that cycle.
- States: IDLE, EXT (after E0), REL (after F0), EXT_REL (after E0 F0), PAUSE (inside the E1 sequence, with a 3-bit skip counter).
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> REL.
  - E1 -> PAUSE, skip counter=7.
  - AA, FA, EE, FE -> dropped, stay in IDLE.
  - 00 or FF -> error pulse, stay in IDLE.
  - Any other byte b -> emit {code=b, ext=0, rel=0}.
- EXT: F0 -> EXT_REL; E0 -> stay in EXT; any other byte b -> emit {b, ext=1, rel=0}, go to IDLE.
- REL: any byte b -> emit {b, 0, 1}, go to IDLE.
- EXT_REL: any byte b -> emit {b, 1, 1}, go to IDLE.
- PAUSE: each byte decrements the skip counter. The byte that takes it to 0 emits {code=8'hE1, ext=1, rel=0} and goes to IDLE. Total sequence length is 8 bytes; no break event is emitted for pause.
- Emit means a FIFO push registered at the end of the rx_complete cycle. ev_valid rises in the next cycle (latency 1 cycle from the strobe). The FIFO is first-word-fall-through: head fields are stable while ev_valid=1 and ev_ready=0.
- FIFO full:
  - A push without a simultaneous pop drops the event and pulses overflow in the following cycle. Contents are unchanged.
  - A push with a simultaneous pop when full is accepted and the count is unchanged.
- FIFO empty: ev_ready is ignored. A push into an empty FIFO is visible the next cycle; the head never bypasses the FIFO combinationally.
- Timeout counter:
  - Cleared on every rx_complete and whenever the state is IDLE.
  - Otherwise increments each cycle.
  - At TIMEOUT_CYCLES-1 the state returns to IDLE, error pulses and the counter clears.
  - If rx_complete arrives in the same cycle the timeout would fire, the byte wins: it is decoded normally and no error is raised.
- rst mid-sequence or mid-FIFO: the partial sequence and all buffered events are discarded, with no pulses.
- Pulse timing: overflow and error are registered and each is high for exactly one cycle per cause. Causes cannot coincide, because only one byte is processed per cycle.

Decomposition:
- Shared package ps2_pkg holds:
  - byte constants: PS2_EXT=8'hE0, PS2_BREAK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT_OK=8'hAA, PS2_ACK=8'hFA, PS2_ECHO=8'hEE, PS2_RESEND=8'hFE, PS2_ERR0=8'h00, PS2_ERR1=8'hFF;
  - the decoder state encoding;
  - the event width EV_W=10 and field order {ext, rel, code[7:0]}.
- One sub-module: ps2_event_fifo. It is a synchronous FWFT FIFO, width EV_W, depth FIFO_DEPTH, with push/pop/full/empty/head ports and synchronous active-high rst. The decoder FSM and timeout counter stay in ps2_key_decoder.

Test Plan:
- Bytes 1C, then F0 1C, with ev_ready=1 -> events {1C,ext0,rel0} then {1C,ext0,rel1}. ev_valid is high one cycle after each final strobe.
- E0 75, then E0 F0 75 -> {75,1,0} then {75,1,1}. E0 E0 6B -> a single {6B,1,0}.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,1,0}, emitted after the 8th byte. A following 1C decodes normally.
- Bytes AA, FA, EE, FE -> no events, no error. Byte FF -> error high for one cycle, no event.
- E0 then idle for 200000 cycles -> error pulses once, state IDLE. A following 1C -> {1C,0,0}, not extended. Also a byte arriving on the expiry cycle -> no error.
- ev_ready=0, push 5 make codes 15 1D 24 2D 2C (depth 4) -> overflow pulses once on the 5th, and the FIFO holds 15 1D 24 2D. A push coinciding with a pop when full -> accepted, no overflow. rst asserted mid-E0 -> ev_valid=0 next cycle.
